ds_link_tx: RTL



---
 rtl/ds_link_pkg.sv | 29 ++
 rtl/ds_bit_tick.sv | 38 +++
 rtl/ds_link_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ds_link_pkg.sv
// Shared DS-link definitions: control codes, character lengths, NULL composition
// and the transmitter state encoding. Also imported by the DS-link receiver.
package ds_link_pkg;

  localparam logic [1:0] CODE_FCT  = 2'b00;
  localparam logic [1:0] CODE_EOP1 = 2'b01;
  localparam logic [1:0] CODE_EOP2 = 2'b10;
  localparam logic [1:0] CODE_ESC  = 2'b11;

  localparam int unsigned DATA_CHAR_LEN = 10;
  localparam int unsigned CTRL_CHAR_LEN = 4;
  localparam int unsigned NULL_CHAR_LEN = 8;
  localparam int unsigned MAX_CHAR_LEN  = DATA_CHAR_LEN;

  // NULL is ESC then FCT; each half is framed as P, F=1, c1, c0 on the wire.
  localparam logic [3:0] NULL_CODES = {CODE_ESC, CODE_FCT};

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LOAD,
    ST_SHIFT
  } ds_tx_state_t;

  // P makes ones(previous char bits) + P + F odd (odd=1) or even (odd=0).
  function automatic logic link_parity(input logic odd, input logic acc, input logic flag);
    return odd ^ acc ^ flag;
  endfunction

endpackage

// File: rtl/ds_bit_tick.sv
// Divide-by-G_CLK_DIV tick generator with synchronous restart. tick_due flags
// that the tick fires on the next cycle (always true when G_CLK_DIV is 1).
module ds_bit_tick #(
  parameter int unsigned G_CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic tick_due
);

  localparam int unsigned CW = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(G_CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

  generate
    if (G_CLK_DIV == 1) begin : g_div1
      assign tick_due = 1'b1;
    end else begin : g_divn
      assign tick_due = (cnt == CW'(G_CLK_DIV - 2));
    end
  endgenerate

endmodule

// File: rtl/ds_link_tx.sv
// IEEE 1355 DS-link character transmitter: one-entry holding register, parity
// generation, NULL fill and Data/Strobe encoding at one bit per G_CLK_DIV cycles.
module ds_link_tx
  import ds_link_pkg::*;
#(
  parameter logic        G_LINK_PARITY_IS_ODD = 1'b1,
  parameter int unsigned G_CLK_DIV            = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_ctrl,
  input  logic [7:0] tx_data,
  output logic       d_out,
  output logic       s_out,
  output logic       char_sent
);

  // LOAD must coincide with the final cycle of the last bit's period. With a
  // divider of 1 that is the cycle right after the last bit is driven.
  localparam logic [3:0] LAST_LEFT = (G_CLK_DIV == 1) ? 4'd1 : 4'd0;

  ds_tx_state_t            state;
  logic                    hold_full;
  logic                    hold_ctrl;
  logic [7:0]              hold_data;
  logic [MAX_CHAR_LEN-1:0] sr;
  logic [3:0]              bits_left;
  logic                    par_acc;
  logic                    cur_user;
  logic                    tick;
  logic                    tick_due;
  logic                    bit_step;
  logic                    go_load;
  logic                    xfer;

  logic [MAX_CHAR_LEN-1:0] load_word;
  logic [3:0]              load_len;
  logic                    load_acc;

  ds_bit_tick #(.G_CLK_DIV(G_CLK_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state != ST_SHIFT),
    .tick     (tick),
    .tick_due (tick_due)
  );

  assign tx_ready = tx_en && !hold_full;
  assign xfer     = tx_valid && tx_ready;
  assign bit_step = (state == ST_SHIFT) && tick && (bits_left != 4'd0);
  assign go_load  = (state == ST_SHIFT) && tick_due && (bits_left == LAST_LEFT);

  // Next character in transmit order (bit 0 first) and the parity it leaves behind.
  always_comb begin
    load_word = '0;
    load_len  = 4'(NULL_CHAR_LEN);
    load_acc  = 1'b0;
    if (hold_full && !hold_ctrl) begin
      load_word = {hold_data, 1'b0, link_parity(G_LINK_PARITY_IS_ODD, par_acc, 1'b0)};
      load_len  = 4'(DATA_CHAR_LEN);
      load_acc  = ^hold_data;
    end else if (hold_full) begin
      load_word = {6'b0, hold_data[0], hold_data[1], 1'b1,
                   link_parity(G_LINK_PARITY_IS_ODD, par_acc, 1'b1)};
      load_len  = 4'(CTRL_CHAR_LEN);
      load_acc  = ^hold_data[1:0];
    end else begin
      load_word = {2'b0, NULL_CODES[0], NULL_CODES[1], 1'b1,
                   link_parity(G_LINK_PARITY_IS_ODD, ^NULL_CODES[3:2], 1'b1),
                   NULL_CODES[2], NULL_CODES[3], 1'b1,
                   link_parity(G_LINK_PARITY_IS_ODD, par_acc, 1'b1)};
      load_acc  = ^NULL_CODES[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      hold_data <= tx_data;
      hold_ctrl <= tx_ctrl;
    end
    if (state == ST_LOAD) begin
      sr <= load_word >> 1;
    end else if (bit_step) begin
      sr <= sr >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      hold_full <= 1'b0;
      par_acc   <= 1'b0;
      bits_left <= 4'd0;
      cur_user  <= 1'b0;
      d_out     <= 1'b0;
      s_out     <= 1'b0;
      char_sent <= 1'b0;
    end else begin
      char_sent <= 1'b0;
      if (xfer) begin
        hold_full <= 1'b1;
      end else if (state == ST_LOAD) begin
        hold_full <= 1'b0;
      end
      if (!tx_en) begin
        // Disconnect: drop the partial character without a char_sent pulse.
        state     <= ST_OFF;
        hold_full <= 1'b0;
        par_acc   <= 1'b0;
        bits_left <= 4'd0;
        cur_user  <= 1'b0;
        d_out     <= 1'b0;
        s_out     <= 1'b0;
      end else begin
        case (state)
          ST_OFF: state <= ST_LOAD;
          ST_LOAD: begin
            d_out     <= load_word[0];
            s_out     <= s_out ^ (load_word[0] == d_out);
            bits_left <= load_len - 4'd1;
            cur_user  <= hold_full;
            par_acc   <= load_acc;
            state     <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (bit_step) begin
              d_out     <= sr[0];
              s_out     <= s_out ^ (sr[0] == d_out);
              bits_left <= bits_left - 4'd1;
              if (bits_left == 4'd1) char_sent <= cur_user;
            end
            if (go_load) state <= ST_LOAD;
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

endmodule
